// File: rtl/gf180mcu_fd_sc_mcu7t5v0__shift_cap_pkg.sv
// Shared definitions for the shift/capture block.
//   WIDTH_DEFAULT : default serial word width
//   state_t       : controller states (IDLE accepts a load, SHIFT streams the
//                   word out while sampling SI, HOLD presents the captured word)
package gf180mcu_fd_sc_mcu7t5v0__shift_cap_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__shift_cap_sreg.sv
// Shift register and shift counter.
//   clk, rst  : clock, synchronous active-high reset (clears word and count)
//   load      : parallel load of ld_data, count restarts at 0
//   shift     : shift right one place, si enters at the MSB
//   ld_data   : parallel word to load
//   si        : serial input bit
//   sreg      : current register contents (bit 0 is the next bit out)
//   cnt_last  : high while the count sits at WIDTH-1 (final shift cycle)
module gf180mcu_fd_sc_mcu7t5v0__shift_cap_sreg
    import gf180mcu_fd_sc_mcu7t5v0__shift_cap_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             si,
    output logic [WIDTH-1:0] sreg,
    output logic             cnt_last
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= ld_data;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= {si, sreg[WIDTH-1:1]};
            // Saturate at the last index; the controller leaves SHIFT on
            // this edge, so the count never needs to wrap.
            if (!cnt_last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign cnt_last = (cnt == CNT_MAX);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__shift_cap.sv
// Serializer/deserializer around an external flop chain: a parallel word is
// loaded, shifted out LSB first on SO for exactly WIDTH cycles while SI is
// shifted in, and the captured word is then held until the consumer takes it.
//   CLK, RST   : clock, synchronous active-high reset
//   LD_VALID/LD_READY/LD_DATA    : load handshake and word to serialize
//   SO, SHIFT_EN                 : serial out and shift strobe to the chain
//   SI                           : serial in from the chain
//   CAP_VALID/CAP_READY/CAP_DATA : captured word handshake
module gf180mcu_fd_sc_mcu7t5v0__shift_cap
    import gf180mcu_fd_sc_mcu7t5v0__shift_cap_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [WIDTH-1:0] LD_DATA,
    output logic             SO,
    output logic             SHIFT_EN,
    input  logic             SI,
    output logic             CAP_VALID,
    input  logic             CAP_READY,
    output logic [WIDTH-1:0] CAP_DATA
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic             cnt_last;
    logic             ld_fire;
    logic             cap_fire;

    // Outputs are gated by RST so everything reads 0 while reset is held,
    // even though the state itself only clears on the next edge.
    assign LD_READY  = (state == ST_IDLE)  & ~RST;
    assign SHIFT_EN  = (state == ST_SHIFT) & ~RST;
    assign CAP_VALID = (state == ST_HOLD)  & ~RST;
    assign SO        = SHIFT_EN & sreg[0];
    assign CAP_DATA  = CAP_VALID ? sreg : '0;

    assign ld_fire  = LD_VALID & LD_READY;
    assign cap_fire = CAP_VALID & CAP_READY;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (ld_fire)  state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt_last) state_nxt = ST_HOLD;
            ST_HOLD:  if (cap_fire) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    gf180mcu_fd_sc_mcu7t5v0__shift_cap_sreg #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .clk      (CLK),
        .rst      (RST),
        .load     (ld_fire),
        .shift    (SHIFT_EN),
        .ld_data  (LD_DATA),
        .si       (SI),
        .sreg     (sreg),
        .cnt_last (cnt_last)
    );

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__shift_cap.sv
// Bench for the shift/capture block. Stimulus loads words with one of three
// serial-input sources (SO looped back, SO through one flop, random bits);
// an expected capture word and its cycle are queued for every accepted load
// and a negedge monitor checks them along with the per-cycle output rules.
module tb_gf180mcu_fd_sc_mcu7t5v0__shift_cap;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_valid;
    logic         ld_ready;
    logic [W-1:0] ld_data;
    logic         so;
    logic         shift_en;
    logic         si;
    logic         cap_valid;
    logic         cap_ready = 1'b0;
    logic [W-1:0] cap_data;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu7t5v0__shift_cap #(
        .WIDTH (W)
    ) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .LD_VALID  (ld_valid),
        .LD_READY  (ld_ready),
        .LD_DATA   (ld_data),
        .SO        (so),
        .SHIFT_EN  (shift_en),
        .SI        (si),
        .CAP_VALID (cap_valid),
        .CAP_READY (cap_ready),
        .CAP_DATA  (cap_data)
    );

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks       = 0;
    int           errors       = 0;
    int           cyc          = 0;
    int           loads        = 0;
    int           win_lo       = 1;
    int           win_hi       = 0;
    int           hold_cnt     = 0;
    int           cr_mode      = 1;
    int           last_cap_cyc = 0;
    int           prev_cap_cyc = 0;
    logic         holding      = 1'b0;
    logic         prev_rst     = 1'b0;
    logic         dq;
    logic [W-1:0] held         = '0;
    logic [W-1:0] act_d        = '0;
    logic [W-1:0] act_r        = '0;
    logic [W-1:0] cur_r        = '0;
    logic [1:0]   act_mode     = 2'd0;
    logic [1:0]   cur_mode     = 2'd0;
    logic [2:0]   sidx;
    logic         rnd_si;

    always @(posedge clk) cyc <= cyc + 1;

    // One-flop stage on SO, cleared by reset.
    always @(posedge clk) dq <= rst ? 1'b0 : so;

    // Position within the current shift window selects the random SI bit.
    assign sidx   = 3'(cyc - win_lo);
    assign rnd_si = act_r[sidx];
    assign si     = (act_mode == 2'd0) ? so :
                    (act_mode == 2'd1) ? dq : rnd_si;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard / consumer
    always @(negedge clk) begin
        exp_t         e;
        logic         rdy;
        logic         in_win;
        logic [W-1:0] d;
        if (rst) begin
            check("rst_outputs", 32'({ld_ready, so, shift_en, cap_valid, cap_data}), 32'd0);
            exp_q.delete();
            holding   = 1'b0;
            win_lo    = 1;
            win_hi    = 0;
            cap_ready = 1'b0;
        end else begin
            in_win = (cyc >= win_lo) && (cyc <= win_hi);
            check("ld_ready", 32'(ld_ready), 32'((exp_q.size() == 0) && !holding));
            check("shift_en", 32'(shift_en), 32'(in_win));
            check("so", 32'(so), 32'(in_win ? act_d[sidx] : 1'b0));
            if (prev_rst) check("ld_ready_after_rst", 32'(ld_ready), 32'd1);
            if (cap_valid) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_cap", 32'(cap_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("cap_data", 32'(cap_data), 32'(e.data));
                        check("cap_cycle", cyc, e.cyc);
                        prev_cap_cyc = last_cap_cyc;
                        last_cap_cyc = cyc;
                    end
                    holding  = 1'b1;
                    held     = cap_data;
                    hold_cnt = 0;
                end else begin
                    check("cap_stable", 32'(cap_data), 32'(held));
                end
                case (cr_mode)
                    1:       rdy = 1'b1;
                    2:       rdy = (hold_cnt >= 5);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                cap_ready = rdy;
                hold_cnt++;
                if (rdy) holding = 1'b0;
            end else begin
                check("cap_data_zero", 32'(cap_data), 32'd0);
                if (holding) begin
                    check("cap_dropped", 32'(cap_valid), 32'd1);
                    holding = 1'b0;
                end
                if ((exp_q.size() != 0) && (cyc >= exp_q[0].cyc)) begin
                    check("cap_missing", 32'(cap_valid), 32'd1);
                    void'(exp_q.pop_front());
                end
                cap_ready = (cr_mode == 1) ? 1'b1 :
                            (cr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            if (ld_valid && ld_ready) begin
                // Load takes effect at the coming edge: shift cycles follow,
                // capture appears WIDTH cycles after the first shift cycle.
                case (cur_mode)
                    2'd0:    d = ld_data;
                    2'd1:    d = ld_data << 1;
                    default: d = cur_r;
                endcase
                e.data = d;
                e.cyc  = cyc + 1 + W;
                exp_q.push_back(e);
                act_d    = ld_data;
                act_r    = cur_r;
                act_mode = cur_mode;
                win_lo   = cyc + 1;
                win_hi   = cyc + W;
                loads++;
            end
        end
        prev_rst = rst;
    end

    task automatic do_load(input logic [W-1:0] d, input logic [1:0] mode, input logic [W-1:0] r,
                           input logic hold_next, input logic [W-1:0] nd);
        int l0;
        int i;
        l0       = loads;
        cur_mode = mode;
        cur_r    = r;
        ld_data  = d;
        ld_valid = 1'b1;
        for (i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (loads != l0) break;
        end
        if (i == 300) check("load_timeout", 32'd0, 32'd1);
        ld_valid = hold_next;
        ld_data  = nd;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if ((exp_q.size() == 0) && !holding) break;
        end
        if (i == 300) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] nd;
        logic         hn;
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Loopback: word comes back unchanged.
        do_load(8'hA5, 2'd0, '0, 1'b0, '0);
        wait_idle();
        // One flop on SO: word comes back shifted up by one.
        do_load(8'hA5, 2'd1, '0, 1'b0, '0);
        wait_idle();
        // Consumer stalls 5 HOLD cycles.
        cr_mode = 2;
        do_load(8'h5A, 2'd0, '0, 1'b0, '0);
        wait_idle();
        cr_mode = 1;
        // Load request held through SHIFT/HOLD with new data.
        do_load(8'hA5, 2'd0, '0, 1'b1, 8'h3C);
        do_load(8'h3C, 2'd0, '0, 1'b0, '0);
        wait_idle();
        // Reset in shift cycle 4 abandons the word.
        do_load(8'hC3, 2'd2, 8'h96, 1'b0, '0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle();
        // Back-to-back loads with consumer always ready.
        cr_mode = 1;
        do_load(8'h01, 2'd0, '0, 1'b1, 8'hFF);
        do_load(8'hFF, 2'd0, '0, 1'b0, '0);
        wait_idle();
        check("b2b_cadence", last_cap_cyc - prev_cap_cyc, 32'(W + 2));

        // Randomized traffic.
        d = W'($urandom);
        for (int i = 0; i < 40; i++) begin
            cr_mode = $urandom_range(0, 1);
            nd      = W'($urandom);
            hn      = 1'($urandom_range(0, 1));
            do_load(d, 2'($urandom_range(0, 2)), W'($urandom), hn, nd);
            if (!hn) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            d = nd;
        end
        cr_mode = 1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__shift_cap.md
GF180MCU_FD_SC_MCU7T5V0__SHIFT_CAP -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__shift_cap

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning shift word width; legal range 2..32.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; one clock, reset synchronous, active-high.
REQ-004 SHALL have port LD_VALID  input  1  load word offered.
REQ-005 SHALL have port LD_READY  output  1  block can accept a load word.
REQ-006 SHALL have port LD_DATA  input  WIDTH  parallel word to serialize, LSB first.
REQ-007 SHALL have port SO  output  1  serial out; drives D of the downstream flop.
REQ-008 SHALL have port SHIFT_EN  output  1  high on every cycle in which a shift occurs.
REQ-009 SHALL have port SI  input  1  serial in; driven by Q of the flop chain.
REQ-010 SHALL have port CAP_VALID  output  1  captured word available.
REQ-011 SHALL have port CAP_READY  input  1  consumer accepts captured word.
REQ-012 SHALL have port CAP_DATA  output  WIDTH  captured parallel word.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, HOLD.
REQ-014 IDLE: LD_READY=1; LD_VALID&LD_READY at an edge loads sreg<=LD_DATA, cnt<=0, next SHIFT.
REQ-015 SHIFT: SHIFT_EN=1, SO=sreg[0] combinationally; each edge sreg<={SI,sreg[WIDTH-1:1]}, cnt<=cnt+1.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, no stall; at edge with cnt==WIDTH-1, next HOLD.
REQ-017 HOLD: CAP_VALID=1, CAP_DATA=sreg stable until CAP_VALID&CAP_READY; then next IDLE.
REQ-018 CAP_DATA[k] SHALL equal SI sampled in shift cycle k (k=0..WIDTH-1).
REQ-019 Latency: load accepted at edge t -> shift cycles t+1..t+WIDTH -> CAP_VALID from cycle t+WIDTH+1.
REQ-020 Outside SHIFT: SO=0, SHIFT_EN=0; outside IDLE: LD_READY=0; outside HOLD: CAP_VALID=0.
REQ-021 LD_VALID SHALL be ignored outside IDLE; CAP_READY ignored outside HOLD.
REQ-022 CAP_READY held high before HOLD SHALL complete handshake in first HOLD cycle (one-cycle HOLD).
REQ-023 Next load earliest the cycle after the CAP handshake (no overlap of load and capture).
REQ-024 cnt width SHALL be clog2(WIDTH+1); never exceeds WIDTH-1; no wrap.
REQ-025 CAP_DATA SHALL read 0 whenever CAP_VALID=0.

Reset
REQ-026 RST high at an edge SHALL force IDLE, sreg=0, cnt=0, dominating any handshake in that cycle.
REQ-027 While RST high all outputs SHALL be 0, including LD_READY; LD_READY=1 first cycle after release.
REQ-028 RST mid-SHIFT or mid-HOLD SHALL abandon the word; no CAP_VALID for it ever.

Structure
REQ-029 Shared package SHALL hold FSM state enum and WIDTH default constant.
REQ-030 Shift register plus counter SHALL be one sub-module, gf180mcu_fd_sc_mcu7t5v0__shift_cap_sreg; FSM in top.

Verification
REQ-031 SI tied to SO, WIDTH=8, load 8'hA5 -> SHIFT_EN high 8 cycles, CAP_DATA=8'hA5 at t+9.
REQ-032 SI from one dffq stage on SO (reset to 0), load 8'hA5 -> CAP_DATA=8'h4A.
REQ-033 CAP_READY low 5 cycles in HOLD -> CAP_VALID, CAP_DATA stable 5 cycles; LD_READY low throughout.
REQ-034 LD_VALID held high during SHIFT with new data 8'h3C -> ignored; 8'h3C loads only after return to IDLE.
REQ-035 RST at shift cycle 4 -> next cycle all outputs 0; no CAP_VALID; LD_READY=1 after release.
REQ-036 CAP_READY held high, back-to-back loads 8'h01, 8'hFF -> each captured in WIDTH+2-cycle cadence, values exact.
